yam430_fetch_seq: RTL and testbench

Instruction fetch and sequencer stage directly upstream of the YAM430 core.
- Reads 16-bit opcodes as two bytes, little-endian, from an 8-bit program memory using a Req/Ack handshake.
- Presents each opcode to the core atomically.
- Generates the per-instruction timing strobes: the save-old-destination strobe and the register-file write strobe.
- Owns the program counter and the halt state.

---
 rtl/yam430_pkg.sv | 17 +
 rtl/yam430_fetch_seq_if.sv | 12 +
 rtl/yam430_fetch_seq.sv | 144 ++++++++++++++
 tb/tb_yam430_fetch_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/yam430_pkg.sv
// Shared types and constants for the YAM430 fetch/sequencer slice.
// Optional single-step build: define YAM430_FETCH_SINGLE_STEP_EN.
package yam430_pkg;

    localparam int YAM430_OPCODE_W = 16;
    localparam logic [YAM430_OPCODE_W-1:0] YAM430_HALT_OPCODE = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_LO,
        ST_FETCH_HI,
        ST_SAVE,
        ST_EXEC,
        ST_HALT
    } yam430_fetch_state_t;

endpackage

// File: rtl/yam430_fetch_seq_if.sv
// Byte-wide program memory Req/Ack bus between the fetch stage and memory.
interface yam430_fetch_seq_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  MemReq;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic                  MemAck;
    logic [7:0]            MemData;

    modport master (output MemReq, output MemAddr, input MemAck, input MemData);
    modport slave  (input MemReq, input MemAddr, output MemAck, output MemData);
endinterface

// File: rtl/yam430_fetch_seq.sv
// YAM430 fetch/sequencer: two-byte opcode fetch, timing strobes, PC, halt.
// Define YAM430_FETCH_SINGLE_STEP_EN to add the Step input (one instr per pulse).
module yam430_fetch_seq
    import yam430_pkg::*;
#(
    parameter int                          ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0]       RESET_PC    = '0,
    parameter logic [YAM430_OPCODE_W-1:0]  HALT_OPCODE = YAM430_HALT_OPCODE
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       Run,
`ifdef YAM430_FETCH_SINGLE_STEP_EN
    input  logic                       Step,
`endif
    yam430_fetch_seq_if.master         mem,
    output logic [YAM430_OPCODE_W-1:0] Opcode,
    output logic                       AluSaveOldDestIn,
    output logic                       RegWrStb,
    output logic                       Halted,
    output logic [15:0]                InstrCount
);

    yam430_fetch_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [7:0] lo_q, lo_d;
    logic [YAM430_OPCODE_W-1:0] op_q, op_d;
    logic req_q, req_d;
    logic save_q, save_d;
    logic wr_q, wr_d;
    logic halt_q, halt_d;
    logic [15:0] cnt_q, cnt_d;
    logic start;
    logic again;

`ifdef YAM430_FETCH_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) step_q <= 1'b0;
        else        step_q <= Step;
    end

    assign start = Run & Step & ~step_q;
    assign again = 1'b0;
`else
    assign start = Run;
    assign again = Run;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lo_d    = lo_q;
        op_d    = op_q;
        req_d   = req_q;
        save_d  = 1'b0;
        wr_d    = 1'b0;
        halt_d  = halt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH_LO;
                    req_d   = 1'b1;
                end
            end
            ST_FETCH_LO: begin
                if (mem.MemAck) begin
                    lo_d    = mem.MemData;
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_FETCH_HI;
                end
            end
            ST_FETCH_HI: begin
                if (mem.MemAck) begin
                    op_d  = {mem.MemData, lo_q};
                    pc_d  = pc_q + 1'b1;
                    req_d = 1'b0;
                    if (op_d == HALT_OPCODE) begin
                        state_d = ST_HALT;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = ST_SAVE;
                        save_d  = 1'b1;
                    end
                end
            end
            ST_SAVE: begin
                state_d = ST_EXEC;
                wr_d    = 1'b1;
            end
            ST_EXEC: begin
                cnt_d = cnt_q + 16'd1;
                if (again) begin
                    state_d = ST_FETCH_LO;
                    req_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (!Run) begin
                    state_d = ST_IDLE;
                    halt_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            lo_q    <= '0;
            op_q    <= '0;
            req_q   <= 1'b0;
            save_q  <= 1'b0;
            wr_q    <= 1'b0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            req_q   <= req_d;
            save_q  <= save_d;
            wr_q    <= wr_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem.MemReq       = req_q;
    assign mem.MemAddr      = pc_q;
    assign Opcode           = op_q;
    assign AluSaveOldDestIn = save_q;
    assign RegWrStb         = wr_q;
    assign Halted           = halt_q;
    assign InstrCount       = cnt_q;

endmodule

// File: tb/tb_yam430_fetch_seq.sv
// Randomized self-checking bench for yam430_fetch_seq against a transaction-level model.
module tb_yam430_fetch_seq;

    logic Clk = 1'b0;
    logic Rst_n;
    logic Run;
`ifdef YAM430_FETCH_SINGLE_STEP_EN
    logic Step = 1'b0;
`endif
    logic [15:0] Opcode, w_op;
    logic Save, Wr, Halted, w_save, w_wr, w_halt;
    logic [15:0] Cnt, w_cnt;

    logic [7:0] mem [256];
    logic [7:0] pc_m;
    logic [15:0] op_m;
    logic [15:0] cnt_m;
    logic [7:0] wrap_q [$];
    int n_chk = 0;
    int n_fail = 0;

    yam430_fetch_seq_if #(.ADDR_WIDTH(8)) m_if ();
    yam430_fetch_seq_if #(.ADDR_WIDTH(8)) w_if ();

    always #5 Clk = ~Clk;

    yam430_fetch_seq u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .Run(Run),
`ifdef YAM430_FETCH_SINGLE_STEP_EN
        .Step(Step),
`endif
        .mem(m_if.master), .Opcode(Opcode), .AluSaveOldDestIn(Save),
        .RegWrStb(Wr), .Halted(Halted), .InstrCount(Cnt)
    );

    yam430_fetch_seq #(.ADDR_WIDTH(8), .RESET_PC(8'hFF)) u_wrap (
        .Clk(Clk), .Rst_n(Rst_n), .Run(Run),
`ifdef YAM430_FETCH_SINGLE_STEP_EN
        .Step(Step),
`endif
        .mem(w_if.master), .Opcode(w_op), .AluSaveOldDestIn(w_save),
        .RegWrStb(w_wr), .Halted(w_halt), .InstrCount(w_cnt)
    );

    // Wrap instance sees a zero-wait memory; log the address of every accepted byte
    assign w_if.MemAck  = w_if.MemReq;
    assign w_if.MemData = mem[w_if.MemAddr];

    always @(negedge Clk)
        if (Rst_n && w_if.MemReq && wrap_q.size() < 3)
            wrap_q.push_back(w_if.MemAddr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_if_idle();
        int n;
        if (!m_if.MemReq) begin
`ifdef YAM430_FETCH_SINGLE_STEP_EN
            Step = 1'b1;
            @(negedge Clk);
            Step = 1'b0;
`endif
            n = 0;
            while (!m_if.MemReq && n < 10) begin
                @(negedge Clk);
                n++;
            end
        end
        chk("start_req", m_if.MemReq, 1);
    endtask

    // One instruction from the model's view: two acked bytes, then strobes or halt
    task automatic fetch_instr(input int waits, input bit drop);
        logic [7:0] b [2];
        logic exp_req;
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < waits; w++) begin
                m_if.MemAck = 1'b0;
                m_if.MemData = 8'($urandom);
                @(negedge Clk);
                chk("addr_wait", m_if.MemAddr, pc_m);
                chk("op_wait", Opcode, op_m);
            end
            chk("addr", m_if.MemAddr, pc_m);
            chk("req_hold", m_if.MemReq, 1);
            b[k] = mem[pc_m];
            m_if.MemData = b[k];
            m_if.MemAck = 1'b1;
            @(negedge Clk);
            pc_m = pc_m + 8'd1;
            if (k == 0) begin
                chk("op_atomic", Opcode, op_m);
                if (drop) Run = 1'b0;
            end
        end
        m_if.MemAck = 1'($urandom);
        m_if.MemData = 8'($urandom);
        op_m = {b[1], b[0]};
        chk("opcode", Opcode, op_m);
        chk("req_off", m_if.MemReq, 0);
        chk("addr_next", m_if.MemAddr, pc_m);
        if (op_m == 16'hFFFF) begin
            m_if.MemAck = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk("halted", Halted, 1);
                chk("halt_nostb", {Save, Wr}, 0);
                chk("halt_cnt", Cnt, cnt_m);
                @(negedge Clk);
            end
        end else begin
            chk("save_stb", {Save, Wr, Halted}, 3'b100);
            @(negedge Clk);
            m_if.MemAck = 1'($urandom);
            chk("wr_stb", {Save, Wr}, 2'b01);
            @(negedge Clk);
            m_if.MemAck = 1'b0;
            cnt_m = cnt_m + 16'd1;
            chk("stb_clear", {Save, Wr}, 0);
            chk("count", Cnt, cnt_m);
            chk("op_kept", Opcode, op_m);
`ifdef YAM430_FETCH_SINGLE_STEP_EN
            exp_req = 1'b0;
`else
            exp_req = Run;
`endif
            chk("req_next", m_if.MemReq, exp_req);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 6; i < 256; i += 2)
            if (mem[i] == 8'hFF && mem[i+1] == 8'hFF) mem[i] = 8'h00;
        mem[0] = 8'h34; mem[1] = 8'h12;
        mem[2] = 8'h34; mem[3] = 8'h12;
        mem[4] = 8'hFF; mem[5] = 8'hFF;
        pc_m = 8'd0;
        op_m = 16'd0;
        cnt_m = 16'd0;
        Rst_n = 1'b0;
        Run = 1'b0;
        m_if.MemAck = 1'b0;
        m_if.MemData = 8'd0;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_req", m_if.MemReq, 0);
        chk("rst_addr", m_if.MemAddr, 0);
        chk("rst_op", Opcode, 0);
        chk("rst_stb", {Save, Wr, Halted}, 0);
        chk("rst_cnt", Cnt, 0);
        chk("rst_wrap_addr", w_if.MemAddr, 8'hFF);

        Rst_n = 1'b1;
        Run = 1'b1;
        start_if_idle();
        fetch_instr(0, 1'b0);
        start_if_idle();
        fetch_instr(3, 1'b0);
        start_if_idle();
        fetch_instr(0, 1'b0);
        Run = 1'b0;
        @(negedge Clk);
        chk("unhalt", Halted, 0);
        chk("idle_req", m_if.MemReq, 0);
        @(negedge Clk);
        chk("idle_stay", m_if.MemReq, 0);

`ifdef YAM430_FETCH_SINGLE_STEP_EN
        // Step held high across a whole instruction still yields one instruction
        Run = 1'b1;
        Step = 1'b1;
        for (int n = 0; n < 10 && !m_if.MemReq; n++) @(negedge Clk);
        fetch_instr(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("step_held_req", m_if.MemReq, 0);
            chk("step_held_cnt", Cnt, cnt_m);
            @(negedge Clk);
        end
        Step = 1'b0;
        @(negedge Clk);
        start_if_idle();
        fetch_instr(0, 1'b0);
`endif

        Run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bit drop;
            drop = ($urandom % 5) == 0;
            start_if_idle();
            fetch_instr(int'($urandom % 4), drop);
            if (drop) begin
                for (int j = 0; j < 3; j++) begin
                    chk("run_drop_req", m_if.MemReq, 0);
                    @(negedge Clk);
                end
                Run = 1'b1;
            end
        end

        chk("wrap_n", wrap_q.size(), 3);
        if (wrap_q.size() == 3) begin
            chk("wrap_lo", wrap_q[0], 8'hFF);
            chk("wrap_hi", wrap_q[1], 8'h00);
            chk("wrap_next", wrap_q[2], 8'h01);
        end

        start_if_idle();
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_req", m_if.MemReq, 0);
        chk("arst_addr", m_if.MemAddr, 0);
        chk("arst_op", Opcode, 0);
        chk("arst_stb", {Save, Wr, Halted}, 0);
        chk("arst_cnt", Cnt, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
